// File: rtl/aesl_deadlock_axis_block_detector.sv
// Deadlock detector: flags a non-idle blocked AXIS/instance pattern held unchanged for CONFIRM_CYCLES; DEADLOCK_MON_STICKY_EN makes BLOCKED terminal until reset.
// Latency: block rises CONFIRM_CYCLES clocks after a stable blocked pattern first appears; pure observer, no backpressure.
module aesl_deadlock_axis_block_detector #(
    parameter int NUM_AXIS       = 2,
    parameter int NUM_INST       = 2,
    parameter int NUM_BLK        = 1,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 16,
    parameter int EVT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_BLK-1:0]  inst_block_sigs,
    output logic                block,
    output logic [4:0]          block_chan,
    output logic [EVT_W-1:0]    block_evt_cnt,
    output logic                suspect
);

    localparam int PAT_W = NUM_AXIS + NUM_BLK;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SUSPECT = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             block_q, block_d;
    logic [4:0]       block_chan_q, block_chan_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             suspect_q, suspect_d;

    logic             cond;
    logic [PAT_W-1:0] pat;
    logic [4:0]       low_idx;

    assign cond = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
    assign pat  = {inst_block_sigs, axis_block_sigs};

    // Lowest stalled AXIS channel; 31 marks a block seen only on sub-instances.
    always_comb begin
        low_idx = 5'd31;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) low_idx = 5'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pat_d        = pat_q;
        block_d      = block_q;
        block_chan_d = block_chan_q;
        evt_d        = evt_q;

        case (state_q)
            ST_IDLE: begin
                if (cond) begin
                    state_d = ST_SUSPECT;
                    cnt_d   = CNT_W'(1);
                    pat_d   = pat;
                end
            end
            ST_SUSPECT: begin
                if (!cond) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (pat != pat_q) begin
                    cnt_d = CNT_W'(1);
                    pat_d = pat;
                end else if (cnt_q == CNT_W'(CONFIRM_CYCLES - 1)) begin
                    state_d      = ST_BLOCKED;
                    block_d      = 1'b1;
                    block_chan_d = low_idx;
                    if (!(&evt_q)) evt_d = evt_q + EVT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BLOCKED: begin
`ifdef DEADLOCK_MON_STICKY_EN
                block_d = 1'b1;
`else
                if (!cond) begin
                    state_d = ST_IDLE;
                    block_d = 1'b0;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                block_d = 1'b0;
            end
        endcase

        suspect_d = (state_d == ST_SUSPECT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pat_q        <= '0;
            block_q      <= 1'b0;
            block_chan_q <= 5'd0;
            evt_q        <= '0;
            suspect_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat_q        <= pat_d;
            block_q      <= block_d;
            block_chan_q <= block_chan_d;
            evt_q        <= evt_d;
            suspect_q    <= suspect_d;
        end
    end

    assign block         = block_q;
    assign block_chan    = block_chan_q;
    assign block_evt_cnt = evt_q;
    assign suspect       = suspect_q;

endmodule

// File: tb/tb_aesl_deadlock_axis_block_detector.sv
// Directed bench for the deadlock detector; a second instance with EVT_W=2 checks counter saturation.
module tb_aesl_deadlock_axis_block_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] axis;
    logic [1:0] idle;
    logic [0:0] iblk;

    logic       block_a, suspect_a;
    logic [4:0] chan_a;
    logic [7:0] evt_a;
    logic       block_b, suspect_b;
    logic [4:0] chan_b;
    logic [1:0] evt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aesl_deadlock_axis_block_detector #(
        .NUM_AXIS(2), .NUM_INST(2), .NUM_BLK(1),
        .CONFIRM_CYCLES(4), .CNT_W(16), .EVT_W(8)
    ) u_dut (
        .clock(clk), .reset(rst),
        .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
        .block(block_a), .block_chan(chan_a), .block_evt_cnt(evt_a), .suspect(suspect_a)
    );

    aesl_deadlock_axis_block_detector #(
        .NUM_AXIS(2), .NUM_INST(2), .NUM_BLK(1),
        .CONFIRM_CYCLES(4), .CNT_W(16), .EVT_W(2)
    ) u_dut_sat (
        .clock(clk), .reset(rst),
        .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
        .block(block_b), .block_chan(chan_b), .block_evt_cnt(evt_b), .suspect(suspect_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are read 1 time unit after the edge.
    task automatic step(input logic [1:0] a, input logic [1:0] id, input logic b, input logic r);
        axis = a;
        idle = id;
        iblk = b;
        rst  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_block"}, 32'(block_a), 0);
        check({tag, "_suspect"}, 32'(suspect_a), 0);
        check({tag, "_chan"}, 32'(chan_a), 0);
        check({tag, "_evt"}, 32'(evt_a), 0);
    endtask

    logic [1:0] sat_exp [5];

    initial begin
`ifdef DEADLOCK_MON_STICKY_EN
        sat_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`else
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif
        step(2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        check_zero("reset");

        // Basic confirmation window on channel 1.
        for (int c = 1; c <= 4; c++) step(2'b00, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(2'b10, 2'b00, 1'b0, 1'b0);
            check("win_block", 32'(block_a), 0);
            check("win_suspect", 32'(suspect_a), 1);
        end
        step(2'b10, 2'b00, 1'b0, 1'b0);
        check("blk_block", 32'(block_a), 1);
        check("blk_chan", 32'(chan_a), 1);
        check("blk_evt", 32'(evt_a), 1);
        check("blk_suspect", 32'(suspect_a), 0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        check("blk_chan_hold", 32'(chan_a), 1);

        // Release: non-sticky drops, sticky holds.
        step(2'b00, 2'b00, 1'b0, 1'b0);
`ifdef DEADLOCK_MON_STICKY_EN
        check("release_block", 32'(block_a), 1);
`else
        check("release_block", 32'(block_a), 0);
        check("release_chan", 32'(chan_a), 1);
`endif
        step(2'b00, 2'b00, 1'b0, 1'b1);
        check_zero("rst_blocked");

        // Interrupted windows never confirm.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                step(2'b01, 2'b00, 1'b0, 1'b0);
                check("intr_block", 32'(block_a), 0);
            end
            check("intr_suspect_hi", 32'(suspect_a), 1);
            step(2'b00, 2'b00, 1'b0, 1'b0);
            check("intr_suspect_lo", 32'(suspect_a), 0);
        end
        check("intr_evt", 32'(evt_a), 0);

        // Reset mid-window restarts the count.
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b1);
        check("midrst_suspect", 32'(suspect_a), 0);
        for (int c = 0; c < 3; c++) begin
            step(2'b01, 2'b00, 1'b0, 1'b0);
            check("midrst_block", 32'(block_a), 0);
        end
        step(2'b01, 2'b00, 1'b0, 1'b0);
        check("midrst_block_hi", 32'(block_a), 1);
        check("midrst_chan", 32'(chan_a), 0);

        // Pattern change restarts the window.
        step(2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(2'b11, 2'b00, 1'b0, 1'b0);
            check("chg_block", 32'(block_a), 0);
        end
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("chg_block_hi", 32'(block_a), 1);
        check("chg_chan", 32'(chan_a), 0);
        check("chg_evt", 32'(evt_a), 1);

        // All-idle masks, then instance-only block.
        step(2'b00, 2'b00, 1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(2'b11, 2'b11, 1'b0, 1'b0);
            check("idle_block", 32'(block_a), 0);
            check("idle_suspect", 32'(suspect_a), 0);
        end
        for (int c = 0; c < 3; c++) step(2'b00, 2'b01, 1'b1, 1'b0);
        check("inst_block_lo", 32'(block_a), 0);
        step(2'b00, 2'b01, 1'b1, 1'b0);
        check("inst_block_hi", 32'(block_a), 1);
        check("inst_chan", 32'(chan_a), 31);
        check("inst_evt", 32'(evt_a), 1);
        step(2'b00, 2'b11, 1'b1, 1'b0);
`ifdef DEADLOCK_MON_STICKY_EN
        check("idle_mask_blocked", 32'(block_a), 1);
`else
        check("idle_mask_blocked", 32'(block_a), 0);
`endif
        check("idle_mask_chan", 32'(chan_a), 31);

        // Saturation of the 2-bit event counter.
        step(2'b00, 2'b00, 1'b0, 1'b1);
        for (int e = 0; e < 5; e++) begin
            for (int c = 0; c < 4; c++) step(2'b01, 2'b00, 1'b0, 1'b0);
            check("sat_block", 32'(block_b), 1);
            check("sat_evt", 32'(evt_b), 32'(sat_exp[e]));
            step(2'b00, 2'b00, 1'b0, 1'b0);
        end
`ifdef DEADLOCK_MON_STICKY_EN
        check("wide_evt", 32'(evt_a), 1);
`else
        check("wide_evt", 32'(evt_a), 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aesl_deadlock_axis_block_detector.md
Name: aesl_deadlock_axis_block_detector

Overview:
Per-kernel deadlock detector placed directly downstream of the kernel monitor top. It consumes that wrapper's packed AXIS-blocked, instance-idle and instance-blocked vectors and raises a registered `block` flag only when a non-idle blocked pattern persists, unchanged, for a confirmation window. It also reports the first blocked AXIS channel and counts block events for the simulation monitor's "find kernel block" report.

Parameters:
NUM_AXIS, 2, width of axis_block_sigs (1..32)
NUM_INST, 2, width of inst_idle_sigs (1..32)
NUM_BLK, 1, width of inst_block_sigs (1..32)
CONFIRM_CYCLES, 16, consecutive stable cycles needed to declare a block (>=2)
CNT_W, 16, width of the confirmation counter; must satisfy 2^CNT_W > CONFIRM_CYCLES
EVT_W, 8, width of the block event counter

Ports:
clock  input  1  kernel monitor clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
axis_block_sigs  input  NUM_AXIS  bit i high = AXIS channel i stalled this cycle
inst_idle_sigs  input  NUM_INST  bit j high = instance j idle
inst_block_sigs  input  NUM_BLK  bit k high = sub-instance k blocked
block  output  1  registered deadlock declaration
block_chan  output  5  index of lowest set axis bit latched at block entry; 31 if only inst_block_sigs were set
block_evt_cnt  output  EVT_W  number of IDLE/SUSPECT->BLOCKED transitions, saturating
suspect  output  1  high while in SUSPECT state (debug)

Behaviour:
- Combinational `cond = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs)`.
- Combinational `pat = {inst_block_sigs, axis_block_sigs}`.
- Registered: `pat_q`.
- FSM states: IDLE, SUSPECT, BLOCKED. Reset -> IDLE, cnt=0, pat_q=0, block=0, block_chan=0, block_evt_cnt=0, suspect=0.
- IDLE:
  - cond=1 -> SUSPECT, cnt<=1, pat_q<=pat.
  - Otherwise stay in IDLE.
- SUSPECT:
  - cond=0 -> IDLE, cnt<=0.
  - cond=1 and pat!=pat_q (progress or pattern change) -> stay in SUSPECT, cnt<=1, pat_q<=pat.
  - cond=1, pat==pat_q, cnt==CONFIRM_CYCLES-1 -> BLOCKED:
    - block<=1.
    - block_chan<=lowest set axis index of pat, or 31 if there is none.
    - block_evt_cnt<=block_evt_cnt+1 unless all ones.
  - Otherwise cnt<=cnt+1.
- Latency: if cond is high with a stable pat on cycles t..t+CONFIRM_CYCLES-1, block is 1 from cycle t+CONFIRM_CYCLES. A cond drop or pat change inside the window restarts it.
- BLOCKED:
  - block stays 1 while cond=1. Pattern changes are ignored; block_chan is held.
  - cond=0 -> IDLE, block<=0, cnt<=0. block_chan holds its last value.
- suspect = (state==SUSPECT), registered alongside the state.
- All-idle instances mask any block bits (cond=0), including in BLOCKED.
- Reset asserted in any state wins over all transitions on that edge, including mid-window and in BLOCKED.
- block_evt_cnt saturates at 2^EVT_W-1. No wrap.
- No X propagation: bits of unused widths are not referenced.

Optional Feature:
DEADLOCK_MON_STICKY_EN:
- Defined: BLOCKED is terminal until reset. block stays 1 and block_chan stays frozen regardless of cond, so a transient release is not hidden from the end-of-run report.
- Undefined: BLOCKED exits to IDLE when cond=0, as described above.

Test Plan:
- Defaults except CONFIRM_CYCLES=4, inst_idle=2'b00. Drive axis=2'b10 for 4 cycles from cycle 5 -> block=0 through cycle 8, block=1 at cycle 9, block_chan=1, block_evt_cnt=1.
- axis=2'b01 for 3 cycles then 0 for 1, repeated -> block never rises, suspect toggles, block_evt_cnt=0.
- axis=2'b01 for 2 cycles, 2'b11 for 4 cycles -> counter restarts on the change, block rises 4 cycles after 2'b11 began, block_chan=0.
- inst_idle=2'b11 with axis=2'b11 for 20 cycles -> block=0, suspect=0 throughout. Then inst_block=1 with axis=0 and inst_idle=2'b01 for 4 cycles -> block=1, block_chan=31.
- In BLOCKED, drop cond -> block=0 next cycle. With DEADLOCK_MON_STICKY_EN defined the same stimulus -> block stays 1. Assert reset for 1 cycle -> all outputs 0 next cycle.
- Set EVT_W=2 and create 5 block episodes -> block_evt_cnt reads 1,2,3,3,3.
